shader_dispatch: RTL and testbench
==================================

// Module: shader_dispatch
// PURPOSE
//  Parametrised, flow-controlled successor to the single-pixel shader FSM.
//  Accepts a pixel stream via valid/ready and normalises coordinates to fixed point.
//  Builds vector-processor requests for the frame's shader mode, keeping up to MAX_OUTSTANDING in flight.
//  Decodes the in-order results to RGB on a valid/ready output. Sits between the display timing and the HDMI encoder.
// PARAMETERS
//  DATA_WIDTH      16   fixed-point word width (two's complement)
//  FRAC_BITS       8    fractional bits; 1.0 = 1<<FRAC_BITS
//  VECTOR_WIDTH    4    lanes per vector; lane 0 = MSB word
//  X_WIDTH         10   pixel x width
//  Y_WIDTH         10   pixel y width
//  SCREEN_W        640  active width (normalisation divisor)
//  SCREEN_H        480  active height
//  CHECK_SHIFT     5    checker cell = 2**CHECK_SHIFT pixels
//  MAX_OUTSTANDING 4    in-flight + buffered results limit; power of 2, >=2
// PORTS
//  clk            in  1                 clock
//  rst            in  1                 async reset, active-high
//  pix_valid      in  1                 pixel coordinate valid
//  pix_ready      out 1                 pixel accepted when valid&ready
//  pix_x          in  X_WIDTH           pixel x
//  pix_y          in  Y_WIDTH           pixel y
//  shader_select  in  4                 shader mode, sampled at frame start
//  vp_req_valid   out 1                 vector request valid
//  vp_req_ready   in  1                 vector processor accepts request
//  vp_operation   out 4                 opcode (1 SUB, 4 SCALE, 5 LENGTH)
//  vp_vec_a       out VECTOR_WIDTH*DATA_WIDTH  operand A
//  vp_vec_b       out VECTOR_WIDTH*DATA_WIDTH  operand B
//  vp_scalar      out DATA_WIDTH        scalar operand
//  vp_rsp_valid   in  1                 result valid (one-cycle pulse, no backpressure)
//  vp_result      in  VECTOR_WIDTH*DATA_WIDTH  result vector
//  rgb_valid      out 1                 colour valid
//  rgb_ready      in  1                 sink accepts colour
//  rgb_red/green/blue out 8 each        colour
//  rgb_sof        out 1                 colour belongs to pixel (0,0)
//  frame_count    out 16                frames started
//  overflow_err   out 1                 sticky: response with nothing outstanding
// BEHAVIOUR
//  Reset: all outputs 0 (pix_ready 0 while rst high); FIFOs empty; mode latch 0; counters 0. Mid-op reset discards all in-flight work.
//  Accept stage: on pix_valid&pix_ready, register norm_x=(pix_x<<FRAC_BITS)/SCREEN_W and norm_y likewise (truncate to DATA_WIDTH).
//  Frame start: if the accepted pixel is (0,0), latch shader_select and increment frame_count (wraps 0xFFFF->0). Mark sof.
//  Request stage (cycle after accept): vp_req_valid=1; operands held stable until vp_req_ready. ONE=1<<FRAC_BITS, HALF=ONE>>1.
//   0 grad-H:  SCALE, a={FF00,0,0,FF00}, scalar=norm_x.
//   1 grad-V:  SCALE, a={0,FF00,0,FF00}, scalar=norm_y.
//   2 radial:  LENGTH, a={norm_x-HALF, norm_y-HALF, 0, 0}.
//   3 checker: SCALE, a=all FF00, scalar=ONE if ((x>>CHECK_SHIFT)^(y>>CHECK_SHIFT))&1, else 0.
//   4 wave:    SCALE, a={w,8000,w,FF00}, w=(norm_x+frame_count[15:8])&FF, scalar=ONE.
//   5..15:     SCALE, a={8000,4000,C000,FF00}, scalar=ONE.
//  pix_ready = (request stage empty | vp_req_valid&vp_req_ready) & credit_ok.
//  Credit: outstanding + result-FIFO count < MAX_OUTSTANDING, so every response always has a slot.
//  Tag FIFO (depth MAX_OUTSTANDING) holds {mode, sof}; push on request handshake, pop on vp_rsp_valid.
//  Responses arrive in request order.
//  Decode on pop into result FIFO. Modes != 2: R=lane0[D-1:D-8], G=lane1[D-1:D-8], B=lane2[D-1:D-8].
//   Mode 2: L=lane0[D-1:D-8]; R=G=L, B=~L.
//  Output: head of result FIFO; rgb_* stable while rgb_valid&!rgb_ready. Simultaneous push/pop keeps count.
//  vp_rsp_valid with tag FIFO empty: response dropped, overflow_err set until rst.
//  Min latency: accept@N, req@N+1 (ready same cycle), rsp@N+1+k -> rgb_valid@N+k+2.
//  Mode changes only at (0,0); pixels already in flight keep their captured mode.
// TESTING
//  Mode 0, pixel (320,0), vp model scales in 1 cycle -> scalar=0x0080, rgb=(7F,00,00), rgb_valid 3 cycles after accept.
//  Mode 3, pixels (0,0),(32,0) -> scalars 0x0000 then 0x0100; rgb 00,00,00 then FF,FF,FF; sof=1 on first only.
//  vp_req_ready held low 10 cycles, rgb_ready low -> exactly MAX_OUTSTANDING pixels accepted, then pix_ready=0; no response lost.
//  shader_select 0->2 mid-frame -> mode switch only after next (0,0); frame_count increments once per (0,0).
//  Spurious vp_rsp_valid at idle -> overflow_err=1 sticky, no rgb_valid; rst mid-burst -> all outputs 0, FIFOs empty.

Source files
------------

// File: rtl/shader_dispatch.sv
// shader_dispatch: pixel stream -> vector-processor requests -> in-order RGB results, with credit-based flow control.
module shader_dispatch #(
  parameter int DATA_WIDTH      = 16,
  parameter int FRAC_BITS       = 8,
  parameter int VECTOR_WIDTH    = 4,
  parameter int X_WIDTH         = 10,
  parameter int Y_WIDTH         = 10,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int CHECK_SHIFT     = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pix_valid,
  output logic                                 pix_ready,
  input  logic [X_WIDTH-1:0]                   pix_x,
  input  logic [Y_WIDTH-1:0]                   pix_y,
  input  logic [3:0]                           shader_select,
  output logic                                 vp_req_valid,
  input  logic                                 vp_req_ready,
  output logic [3:0]                           vp_operation,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_vec_a,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_vec_b,
  output logic [DATA_WIDTH-1:0]                vp_scalar,
  input  logic                                 vp_rsp_valid,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vp_result,
  output logic                                 rgb_valid,
  input  logic                                 rgb_ready,
  output logic [7:0]                           rgb_red,
  output logic [7:0]                           rgb_green,
  output logic [7:0]                           rgb_blue,
  output logic                                 rgb_sof,
  output logic [15:0]                          frame_count,
  output logic                                 overflow_err
);
  localparam int D   = DATA_WIDTH;
  localparam int VW  = VECTOR_WIDTH * DATA_WIDTH;
  localparam int AW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int NXW = X_WIDTH + FRAC_BITS;
  localparam int NYW = Y_WIDTH + FRAC_BITS;
  localparam logic [D-1:0] ONE    = D'(1) << FRAC_BITS;
  localparam logic [D-1:0] HALF   = ONE >> 1;
  localparam logic [D-1:0] ZERO   = '0;
  localparam logic [D-1:0] K_FF00 = D'(16'hFF00);
  localparam logic [D-1:0] K_8000 = D'(16'h8000);
  localparam logic [D-1:0] K_4000 = D'(16'h4000);
  localparam logic [D-1:0] K_C000 = D'(16'hC000);
  logic accept, start, req_hs, rsp_ok, rgb_hs, credit_ok;
  logic [NXW-1:0] nx_w;
  logic [NYW-1:0] ny_w;
  logic req_valid, req_sof, req_chk;
  logic [3:0] mode_q, req_mode;
  logic [D-1:0] nx_q, ny_q, w, scalar;
  logic [3:0][D-1:0] a4;
  logic [4:0] tag_mem [MAX_OUTSTANDING];
  logic [24:0] res_mem [MAX_OUTSTANDING];
  logic [AW-1:0] tag_wr, tag_rd, res_wr, res_rd;
  logic [CW-1:0] tag_cnt, res_cnt;
  logic [CW:0] inflight;
  logic [7:0] l0, l1, l2;
  logic [24:0] dec;
  logic unused_ok;
  assign nx_w = {pix_x, {FRAC_BITS{1'b0}}} / NXW'(SCREEN_W);
  assign ny_w = {pix_y, {FRAC_BITS{1'b0}}} / NYW'(SCREEN_H);
  // The request stage counts against the credit so a stalled request can never overfill the tag FIFO.
  assign inflight  = (CW+1)'(tag_cnt) + (CW+1)'(res_cnt) + (CW+1)'(req_valid);
  assign credit_ok = inflight < (CW+1)'(MAX_OUTSTANDING);
  assign req_hs    = req_valid & vp_req_ready;
  assign pix_ready = ~rst & (~req_valid | req_hs) & credit_ok;
  assign accept    = pix_valid & pix_ready;
  assign start     = accept & (pix_x == '0) & (pix_y == '0);
  assign rsp_ok    = vp_rsp_valid & (tag_cnt != '0);
  assign rgb_valid = res_cnt != '0;
  assign rgb_hs    = rgb_valid & rgb_ready;
  always_comb begin
    w      = (nx_q + D'(frame_count[15:8])) & D'(8'hFF);
    a4     = {K_8000, K_4000, K_C000, K_FF00};
    scalar = ONE;
    case (req_mode)
      4'd0: begin a4 = {K_FF00, ZERO, ZERO, K_FF00}; scalar = nx_q; end
      4'd1: begin a4 = {ZERO, K_FF00, ZERO, K_FF00}; scalar = ny_q; end
      4'd2: begin a4 = {nx_q - HALF, ny_q - HALF, ZERO, ZERO}; scalar = ZERO; end
      4'd3: begin a4 = {K_FF00, K_FF00, K_FF00, K_FF00}; scalar = req_chk ? ONE : ZERO; end
      4'd4: a4 = {w, K_8000, w, K_FF00};
      default: ;
    endcase
  end
  assign vp_req_valid = req_valid;
  assign vp_operation = req_valid ? ((req_mode == 4'd2) ? 4'd5 : 4'd4) : 4'd0;
  assign vp_vec_a     = req_valid ? (VW'(a4) << (VW - 4*D)) : '0;
  assign vp_vec_b     = '0;
  assign vp_scalar    = req_valid ? scalar : '0;
  assign l0  = vp_result[VW-1 -: 8];
  assign l1  = vp_result[VW-D-1 -: 8];
  assign l2  = vp_result[VW-2*D-1 -: 8];
  assign dec = (tag_mem[tag_rd][4:1] == 4'd2) ? {tag_mem[tag_rd][0], l0, l0, ~l0}
                                              : {tag_mem[tag_rd][0], l0, l1, l2};
  assign {rgb_sof, rgb_red, rgb_green, rgb_blue} = rgb_valid ? res_mem[res_rd] : 25'd0;
  assign unused_ok = ^{vp_result, nx_w, ny_w};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid    <= 1'b0;
      req_sof      <= 1'b0;
      req_chk      <= 1'b0;
      req_mode     <= '0;
      mode_q       <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      frame_count  <= '0;
      tag_wr       <= '0;
      tag_rd       <= '0;
      res_wr       <= '0;
      res_rd       <= '0;
      tag_cnt      <= '0;
      res_cnt      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (accept) begin
        req_valid <= 1'b1;
        nx_q      <= D'(nx_w);
        ny_q      <= D'(ny_w);
        req_chk   <= pix_x[CHECK_SHIFT] ^ pix_y[CHECK_SHIFT];
        req_sof   <= start;
        req_mode  <= start ? shader_select : mode_q;
      end else if (req_hs) req_valid <= 1'b0;
      if (start) begin
        mode_q      <= shader_select;
        frame_count <= frame_count + 16'd1;
      end
      if (req_hs) tag_wr <= tag_wr + AW'(1);
      if (rsp_ok) begin
        tag_rd <= tag_rd + AW'(1);
        res_wr <= res_wr + AW'(1);
      end
      if (rgb_hs) res_rd <= res_rd + AW'(1);
      tag_cnt <= tag_cnt + CW'(req_hs) - CW'(rsp_ok);
      res_cnt <= res_cnt + CW'(rsp_ok) - CW'(rgb_hs);
      if (vp_rsp_valid && tag_cnt == '0) overflow_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (req_hs) tag_mem[tag_wr] <= {req_mode, req_sof};
    if (rsp_ok) res_mem[res_wr] <= dec;
  end
endmodule

// File: tb/tb_shader_dispatch.sv
// tb_shader_dispatch: directed + randomized bench with a transaction-level reference model and vector-processor responder.
module tb_shader_dispatch;
  localparam int M = 4;
  logic clk = 0, rst = 1;
  logic pix_valid = 0, pix_ready;
  logic [9:0] pix_x = 0, pix_y = 0;
  logic [3:0] shader_select = 0;
  logic vp_req_valid, vp_req_ready = 1;
  logic [3:0] vp_operation;
  logic [63:0] vp_vec_a, vp_vec_b;
  logic [15:0] vp_scalar;
  logic vp_rsp_valid = 0;
  logic [63:0] vp_result = 0;
  logic rgb_valid, rgb_ready = 1, rgb_sof, overflow_err;
  logic [7:0] rgb_red, rgb_green, rgb_blue;
  logic [15:0] frame_count, fc0;
  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [15:0] s;
    logic [3:0]  mode;
    logic        sof;
  } req_t;
  req_t req_q[$];
  logic [63:0] rsp_q[$];
  logic [24:0] exp_q[$], log_q[$];
  logic [15:0] fc_m = 0;
  logic [3:0] mode_m = 0;
  int checks = 0, failures = 0, accepted = 0, emitted = 0, base = 0, rsp_pct = 100;
  bit rsp_auto = 1, prev_hold = 0;
  logic [24:0] prev_rgb = 0;

  shader_dispatch dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .shader_select(shader_select), .vp_req_valid(vp_req_valid), .vp_req_ready(vp_req_ready),
    .vp_operation(vp_operation), .vp_vec_a(vp_vec_a), .vp_vec_b(vp_vec_b), .vp_scalar(vp_scalar),
    .vp_rsp_valid(vp_rsp_valid), .vp_result(vp_result), .rgb_valid(rgb_valid), .rgb_ready(rgb_ready),
    .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue), .rgb_sof(rgb_sof),
    .frame_count(frame_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic req_t model_req(int x, int y, logic [3:0] m, logic [15:0] fc, logic sof);
    logic [15:0] nx, ny, w;
    req_t e;
    nx = 16'((x * 256) / 640);
    ny = 16'((y * 256) / 480);
    w = (nx + {8'h00, fc[15:8]}) & 16'h00FF;
    e.mode = m; e.sof = sof; e.op = 4'd4; e.s = 16'h0100;
    case (m)
      4'd0: begin e.a = {16'hFF00, 16'h0, 16'h0, 16'hFF00}; e.s = nx; end
      4'd1: begin e.a = {16'h0, 16'hFF00, 16'h0, 16'hFF00}; e.s = ny; end
      4'd2: begin e.op = 4'd5; e.a = {nx - 16'd128, ny - 16'd128, 32'h0}; e.s = 16'h0; end
      4'd3: begin e.a = {4{16'hFF00}}; e.s = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'h0100 : 16'h0; end
      4'd4: e.a = {w, 16'h8000, w, 16'hFF00};
      default: e.a = {16'h8000, 16'h4000, 16'hC000, 16'hFF00};
    endcase
    return e;
  endfunction

  // Vector processor behaviour: unsigned fixed-point SCALE, Manhattan-style LENGTH into lane 0.
  function automatic logic [63:0] vp_fn(req_t e);
    logic [63:0] r;
    logic [31:0] p;
    int ax, ay;
    r = '0;
    if (e.op == 4'd5) begin
      ax = int'($signed(e.a[63:48]));
      ay = int'($signed(e.a[47:32]));
      r[63:48] = 16'(((ax < 0 ? -ax : ax) + (ay < 0 ? -ay : ay)) * 64);
    end else
      for (int i = 0; i < 4; i++) begin
        p = 32'(e.a[i*16 +: 16]) * 32'(e.s);
        r[i*16 +: 16] = p[23:8];
      end
    return r;
  endfunction

  function automatic logic [23:0] color(logic [63:0] r, logic [3:0] m);
    return (m == 4'd2) ? {r[63:56], r[63:56], ~r[63:56]} : {r[63:56], r[47:40], r[31:24]};
  endfunction

  task automatic observe();
    req_t e;
    logic start;
    chk("frame_count", frame_count, fc_m);
    if (prev_hold) chk("rgb_hold", {rgb_valid, rgb_sof, rgb_red, rgb_green, rgb_blue}, {1'b1, prev_rgb});
    if (rgb_valid) chk("rgb_expected", exp_q.size() > 0, 1);
    if (rgb_valid && rgb_ready) begin
      if (exp_q.size() > 0) chk("rgb", {rgb_sof, rgb_red, rgb_green, rgb_blue}, exp_q.pop_front());
      log_q.push_back({rgb_sof, rgb_red, rgb_green, rgb_blue});
      emitted++;
    end
    if (vp_rsp_valid && rsp_auto && rsp_q.size() > 0) void'(rsp_q.pop_front());
    if (vp_req_valid && vp_req_ready) begin
      chk("req_expected", req_q.size() > 0, 1);
      if (req_q.size() > 0) begin
        e = req_q.pop_front();
        chk("req_op", vp_operation, e.op);
        chk("req_vec_a", vp_vec_a, e.a);
        if (e.op != 4'd5) chk("req_scalar", vp_scalar, e.s);
        rsp_q.push_back(vp_fn(e));
        exp_q.push_back({e.sof, color(vp_fn(e), e.mode)});
      end
    end
    if (pix_valid && pix_ready) begin
      start = (pix_x == 0) && (pix_y == 0);
      if (start) begin fc_m++; mode_m = shader_select; end
      req_q.push_back(model_req(int'(pix_x), int'(pix_y), mode_m, fc_m, start));
      accepted++;
    end
    chk("credit", (accepted - emitted) <= M, 1);
    prev_hold = rgb_valid && !rgb_ready;
    prev_rgb = {rgb_sof, rgb_red, rgb_green, rgb_blue};
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (rsp_auto) begin
      vp_rsp_valid = rsp_q.size() > 0 && $urandom_range(99) < rsp_pct;
      vp_result = vp_rsp_valid ? rsp_q[0] : 64'h0;
    end
  endtask

  task automatic send(input int x, input int y);
    int n;
    n = accepted;
    pix_valid = 1; pix_x = 10'(x); pix_y = 10'(y);
    for (int i = 0; i < 50 && accepted == n; i++) tick();
    chk("send_accept", accepted, n + 1);
    pix_valid = 0;
  endtask

  task automatic drain();
    pix_valid = 0; vp_req_ready = 1; rgb_ready = 1;
    for (int i = 0; i < 400 && accepted != emitted; i++) tick();
    chk("drain", accepted - emitted, 0);
  endtask

  initial begin
    pix_valid = 1; pix_x = 5; pix_y = 5;
    tick();
    chk("rst_ctrl", {pix_ready, vp_req_valid, vp_operation, rgb_valid, rgb_sof, rgb_red, rgb_green, rgb_blue,
                     frame_count, overflow_err}, 0);
    chk("rst_vec", {vp_vec_a, vp_vec_b}, 0);
    rst = 0; pix_valid = 0;
    tick();
    // Mode 0, pixel (320,0), single-cycle processor.
    send(320, 0);
    chk("m0_scalar", {vp_req_valid, vp_scalar}, {1'b1, 16'h0080});
    tick();
    chk("m0_latency_early", rgb_valid, 0);
    tick();
    chk("m0_rgb", {rgb_valid, rgb_red, rgb_green, rgb_blue}, {1'b1, 24'h7F0000});
    drain();
    // Mode 3 checker across a frame start.
    shader_select = 3;
    send(0, 0);
    chk("chk_scalar0", {vp_req_valid, vp_scalar}, {1'b1, 16'h0000});
    chk("chk_fc", frame_count, 1);
    send(32, 0);
    chk("chk_scalar1", {vp_req_valid, vp_scalar}, {1'b1, 16'h0100});
    drain();
    chk("chk_px0", log_q[log_q.size()-2], {1'b1, 24'h000000});
    chk("chk_px1", log_q[log_q.size()-1], {1'b0, 24'hFFFFFF});
    // Backpressure on both sides: credit caps accepted pixels.
    vp_req_ready = 0; rgb_ready = 0; base = accepted;
    pix_valid = 1; pix_x = 7; pix_y = 9;
    repeat (10) tick();
    chk("bp_stalled", accepted - base, 1);
    vp_req_ready = 1;
    repeat (20) tick();
    chk("bp_max", accepted - base, M);
    chk("bp_pix_ready", {pix_ready, rgb_valid}, 2'b01);
    drain();
    // Mode change waits for the next frame start.
    shader_select = 2;
    send(100, 50);
    chk("ms_keep_op", vp_operation, 4);
    fc0 = frame_count;
    send(0, 0);
    chk("ms_switch_op", vp_operation, 5);
    chk("ms_fc_inc", frame_count, fc0 + 16'd1);
    send(200, 100);
    chk("ms_op_held", {vp_operation, frame_count}, {4'd5, fc0 + 16'd1});
    drain();
    // Randomized traffic.
    rsp_pct = 60;
    for (int i = 0; i < 800; i++) begin
      pix_valid = $urandom_range(3) != 0;
      if ($urandom_range(19) == 0) begin pix_x = 0; pix_y = 0; end
      else begin pix_x = 10'($urandom_range(639)); pix_y = 10'($urandom_range(479)); end
      shader_select = 4'($urandom_range(15));
      vp_req_ready = $urandom_range(3) != 0;
      rgb_ready = $urandom_range(2) != 0;
      tick();
    end
    drain();
    rsp_pct = 100;
    // Spurious response at idle.
    rsp_auto = 0; vp_rsp_valid = 1; vp_result = 64'hDEAD_BEEF_0123_4567;
    tick();
    vp_rsp_valid = 0;
    chk("ovf_set", {overflow_err, rgb_valid}, 2'b10);
    repeat (5) tick();
    chk("ovf_sticky", {overflow_err, rgb_valid}, 2'b10);
    rsp_auto = 1;
    // Asynchronous reset in the middle of a burst.
    rgb_ready = 0; shader_select = 0; pix_valid = 1; pix_x = 5; pix_y = 5;
    repeat (6) tick();
    chk("burst_busy", rgb_valid, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_ctrl", {pix_ready, vp_req_valid, vp_operation, rgb_valid, rgb_sof, rgb_red, rgb_green, rgb_blue,
                         frame_count, overflow_err}, 0);
    chk("mid_rst_vec", {vp_vec_a, vp_scalar}, 0);
    req_q.delete(); rsp_q.delete(); exp_q.delete();
    fc_m = 0; mode_m = 0; accepted = 0; emitted = 0; prev_hold = 0;
    vp_rsp_valid = 0; pix_valid = 0;
    tick();
    tick();
    rst = 0;
    tick();
    chk("post_rst", {rgb_valid, overflow_err, frame_count, vp_req_valid}, 0);
    rgb_ready = 1; shader_select = 1;
    send(0, 0);
    drain();
    chk("post_rst_px", {log_q[log_q.size()-1], frame_count}, {1'b1, 24'h0, 16'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
